// File: rtl/mem_resp_pkg.sv
// Shared definitions for mem_responder: address map, timer register offsets,
// control bit positions, FSM states and the address decoder.
package mem_resp_pkg;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
  localparam logic [15:0] REG_BASE  = 16'h4000;

  localparam logic [2:0] OFF_DISP     = 3'd0;
  localparam logic [2:0] OFF_RELOAD_L = 3'd1;
  localparam logic [2:0] OFF_RELOAD_H = 3'd2;
  localparam logic [2:0] OFF_CTRL     = 3'd3;
  localparam logic [2:0] OFF_COUNT_L  = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_EXP  = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_e;

  typedef enum logic [2:0] {
    SEL_RAM, SEL_DISP, SEL_RELOAD_L, SEL_RELOAD_H,
    SEL_CTRL, SEL_COUNT_L, SEL_SNAP_H, SEL_NONE
  } sel_e;

  function automatic sel_e decode_addr(input logic [15:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    if ((addr - RAM_BASE) <= (RAM_LIMIT - RAM_BASE)) begin
      sel = SEL_RAM;
    end else if (addr[15:3] == REG_BASE[15:3]) begin
      case (addr[2:0])
        OFF_DISP:     sel = SEL_DISP;
        OFF_RELOAD_L: sel = SEL_RELOAD_L;
        OFF_RELOAD_H: sel = SEL_RELOAD_H;
        OFF_CTRL:     sel = SEL_CTRL;
        OFF_COUNT_L:  sel = SEL_COUNT_L;
        OFF_SNAP_H:   sel = SEL_SNAP_H;
        default:      sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/resp_timer.sv
// 16-bit programmable down-counter with reload, expired flag and count snapshot.
// Interrupt output is built only when MEM_RESP_TIMER_IRQ_EN is defined.
module resp_timer
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       acc_en,
  input  logic       acc_we,
  input  sel_e       acc_sel,
  input  logic [7:0] acc_wdata,
  output logic [7:0] rd_data,
  output logic       irq
);

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  snap_q, snap_d;
  logic        expire;

`ifdef MEM_RESP_TIMER_IRQ_EN
  localparam logic IRQ_IMPL = 1'b1;
  logic irq_q, irq_d;

  always_comb irq_d = exp_q & ie_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  localparam logic IRQ_IMPL = 1'b0;
  assign irq = 1'b0;
`endif

  assign expire = en_q && (count_q == 16'd0);

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    exp_d    = exp_q;
    reload_d = reload_q;
    count_d  = count_q;
    snap_d   = snap_q;

    if (en_q) begin
      if (expire) begin
        exp_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    // A CPU write overrides the enable, but never clears a flag that is setting now.
    if (acc_en && acc_we) begin
      case (acc_sel)
        SEL_RELOAD_L: reload_d[7:0]  = acc_wdata;
        SEL_RELOAD_H: reload_d[15:8] = acc_wdata;
        SEL_CTRL: begin
          en_d   = acc_wdata[CTRL_EN];
          auto_d = acc_wdata[CTRL_AUTO];
          ie_d   = IRQ_IMPL & acc_wdata[CTRL_IE];
          if (acc_wdata[CTRL_EN] && !en_q) count_d = reload_q;
          if (acc_wdata[CTRL_EXP] && !expire) exp_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (acc_en && !acc_we && acc_sel == SEL_COUNT_L) snap_d = count_q[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      reload_q <= 16'h0000;
      count_q  <= 16'h0000;
      snap_q   <= 8'h00;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (acc_sel)
      SEL_RELOAD_L: rd_data = reload_q[7:0];
      SEL_RELOAD_H: rd_data = reload_q[15:8];
      SEL_CTRL:     rd_data = {exp_q, 4'b0000, ie_q, auto_q, en_q};
      SEL_COUNT_L:  rd_data = count_q[7:0];
      SEL_SNAP_H:   rd_data = snap_q;
      default:      rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: request FSM with wait states, mirrored RAM, display latch
// and timer. Optional timer interrupt enabled by defining MEM_RESP_TIMER_IRQ_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int RAM_AW      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_req,
  input  logic [7:0] mem_addr_h,
  input  logic [7:0] mem_addr_l,
  input  logic       mem_rw,
  input  logic [7:0] mem_wdata,
  output logic       mem_rdy,
  output logic       mem_ack,
  output logic [7:0] mem_rdata,
  output logic       mem_rdata_oe,
  output logic [7:0] disp_out,
  output logic       irq
);

  localparam logic       HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        oe_q, oe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        from_ram_q, from_ram_d;
  logic [7:0]  disp_q, disp_d;

  logic        capture, access, ram_we, ram_re;
  sel_e        sel;
  logic [7:0]  tmr_rdata;

  logic [7:0]          ram_mem [2**RAM_AW];
  logic [7:0]          ram_rd_q;
  logic [RAM_AW-1:0]   ram_idx;

  assign sel     = decode_addr(addr_q);
  assign ram_idx = addr_q[RAM_AW-1:0];

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) state_d = ST_ACCESS;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rdy = (state_q == ST_IDLE);
    capture = (state_q == ST_IDLE) && mem_req;
    access  = (state_q == ST_ACCESS);
    ram_we  = access && rw_q && (sel == SEL_RAM);
    ram_re  = access && !rw_q && (sel == SEL_RAM);
  end

  always_comb begin
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    from_ram_d = from_ram_q;
    disp_d     = disp_q;
    ack_d      = access;
    oe_d       = access && !rw_q;

    if (capture) begin
      addr_d  = {mem_addr_h, mem_addr_l};
      rw_d    = mem_rw;
      wdata_d = mem_wdata;
    end

    if (access && rw_q && sel == SEL_DISP) disp_d = wdata_q;

    // Unmapped reads leave both read registers alone, giving open-bus behaviour.
    if (access && !rw_q) begin
      case (sel)
        SEL_RAM:  from_ram_d = 1'b1;
        SEL_DISP: begin
          rdata_d    = disp_q;
          from_ram_d = 1'b0;
        end
        SEL_NONE: ;
        default: begin
          rdata_d    = tmr_rdata;
          from_ram_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 16'h0000;
      rw_q       <= 1'b0;
      wdata_q    <= 8'h00;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      rdata_q    <= 8'h00;
      from_ram_q <= 1'b0;
      disp_q     <= 8'h00;
    end else begin
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
      from_ram_q <= from_ram_d;
      disp_q     <= disp_d;
    end
  end

  // NOTE: the RAM array and its read register take no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_idx] <= wdata_q;
    if (ram_re) ram_rd_q <= ram_mem[ram_idx];
  end

  resp_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .acc_en    (access),
    .acc_we    (rw_q),
    .acc_sel   (sel),
    .acc_wdata (wdata_q),
    .rd_data   (tmr_rdata),
    .irq       (irq)
  );

  assign mem_ack      = ack_q;
  assign mem_rdata_oe = oe_q;
  assign mem_rdata    = from_ram_q ? ram_rd_q : rdata_q;
  assign disp_out     = disp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 3 wait states) against a
// behavioural model of the memory map, handshake timing and timer.
module tb_mem_responder;

`ifdef MEM_RESP_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0, rw = '0, rdy, ack, oe, irq;
  logic [7:0] ah [2], al [2], wd [2], rdata [2], disp [2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_acc = 0;

  logic [7:0]  ram_m [2][2048];
  logic [10:0] wr_idx [2][$];
  logic [7:0]  last_rd [2];
  logic [7:0]  disp_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_addr_h(ah[0]), .mem_addr_l(al[0]),
    .mem_rw(rw[0]), .mem_wdata(wd[0]), .mem_rdy(rdy[0]), .mem_ack(ack[0]),
    .mem_rdata(rdata[0]), .mem_rdata_oe(oe[0]), .disp_out(disp[0]), .irq(irq[0])
  );

  mem_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_addr_h(ah[1]), .mem_addr_l(al[1]),
    .mem_rw(rw[1]), .mem_wdata(wd[1]), .mem_rdy(rdy[1]), .mem_ack(ack[1]),
    .mem_rdata(rdata[1]), .mem_rdata_oe(oe[1]), .disp_out(disp[1]), .irq(irq[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction, issued at a falling edge; returns at the falling edge of the ack cycle.
  task automatic xact(input int d, input logic w, input logic [15:0] a, input logic [7:0] data,
                      input bit glitch, output logic [7:0] rd, output int acc);
    int lat, rdy_low;
    check("rdy_before_req", rdy[d], 1);
    req[d] = 1'b1; rw[d] = w; ah[d] = a[15:8]; al[d] = a[7:0]; wd[d] = data;
    @(negedge clk);
    req[d] = 1'b0; lat = 1; rdy_low = 0;
    while (ack[d] !== 1'b1 && lat < 40) begin
      if (rdy[d] === 1'b0) rdy_low++;
      if (glitch && lat == 2) begin
        req[d] = 1'b1; rw[d] = 1'b1; ah[d] = 8'h40; al[d] = 8'h00; wd[d] = 8'h55;
      end else begin
        req[d] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    acc = cyc;
    rd  = rdata[d];
    check("ack_latency", lat, 2 + ws(d));
    check("rdy_low_cycles", rdy_low, 1 + ws(d));
    check("rdata_oe", oe[d], !w);
    check("rdy_in_ack_cycle", rdy[d], 1);
  endtask

  task automatic wr(input int d, input logic [15:0] a, input logic [7:0] v);
    logic [7:0] rd;
    int acc;
    xact(d, 1'b1, a, v, 1'b0, rd, acc);
    if (a <= 16'h1FFF) begin
      ram_m[d][a[10:0]] = v;
      wr_idx[d].push_back(a[10:0]);
    end else if (a == 16'h4000) begin
      disp_m[d] = v;
    end
    last_acc = acc;
  endtask

  task automatic rd_exp(input int d, input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] rd;
    int acc;
    xact(d, 1'b0, a, 8'h00, 1'b0, rd, acc);
    check(tag, rd, exp);
    last_rd[d] = exp;
    last_acc   = acc;
  endtask

  function automatic logic [7:0] model_read(input int d, input logic [15:0] a);
    if (a <= 16'h1FFF) return ram_m[d][a[10:0]];
    if (a == 16'h4000) return disp_m[d];
    return last_rd[d];
  endfunction

  task automatic gap(input int max_cycles);
    repeat ($urandom_range(max_cycles, 0)) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] a;
    int acc, e, x, n, irq_at, v;

    for (int d = 0; d < 2; d++) begin
      ah[d] = 8'h00; al[d] = 8'h00; wd[d] = 8'h00;
      last_rd[d] = 8'h00; disp_m[d] = 8'h00;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_rdy", rdy[d], 1);
      check("reset_ack", ack[d], 0);
      check("reset_rdata", rdata[d], 8'h00);
      check("reset_oe", oe[d], 0);
      check("reset_disp", disp[d], 8'h00);
      check("reset_irq", irq[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Mirrored RAM, no wait states.
    wr(0, 16'h0123, 8'hA5);
    rd_exp(0, 16'h0923, 8'hA5, "mirror_read");

    // Three wait states, with a request pulsed mid-wait that must be ignored.
    wr(1, 16'h0000, 8'h3C);
    xact(1, 1'b0, 16'h0000, 8'h00, 1'b1, rd, acc);
    check("ws3_read", rd, 8'h3C);
    last_rd[1] = 8'h3C;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] === 1'b1) n++;
    end
    check("no_extra_ack", n, 0);
    check("glitch_write_dropped", disp[1], 8'h00);

    // Display latch and open-bus read.
    wr(0, 16'h4000, 8'h7E);
    @(negedge clk);
    check("disp_after_write", disp[0], 8'h7E);
    rd_exp(0, 16'h4000, 8'h7E, "disp_read");
    rd_exp(0, 16'h2000, last_rd[0], "open_bus_read");

    // Random traffic against the memory-map model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        case ($urandom_range(4, 0))
          0, 1: begin
            a = 16'($urandom_range(16'h1FFF, 0));
            wr(d, a, 8'($urandom));
          end
          2, 3: begin
            a = {3'b000, 2'($urandom_range(3, 0)), wr_idx[d][$urandom_range(wr_idx[d].size() - 1, 0)]};
            rd_exp(d, a, model_read(d, a), "rand_ram_read");
          end
          default: begin
            a = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(16'h3FFF, 16'h2000))
                                            : 16'($urandom_range(16'hFFFF, 16'h4008));
            if ($urandom_range(1, 0) == 1) wr(d, a, 8'($urandom));
            else rd_exp(d, a, model_read(d, a), "rand_unmapped_read");
          end
        endcase
        gap(2);
      end
    end

    // Timer: reload 3, auto-reload, irq enable; expiry every 4 cycles after enable.
    wr(0, 16'h4001, 8'h03);
    wr(0, 16'h4002, 8'h00);
    wr(0, 16'h4003, 8'h07);
    e = last_acc;
    irq_at = -1;
    while (cyc < e + 12) begin
      if (irq[0] === 1'b1 && irq_at < 0) irq_at = cyc;
      @(negedge clk);
    end
    check("irq_rise_cycle", irq_at, IRQ_ON ? e + 5 : -1);

    x = e + 4;
    while (x - 2 < cyc) x += 4;
    while (cyc < x - 2) @(negedge clk);
    wr(0, 16'h4003, 8'h87);
    check("clear_on_expiry_edge", last_acc, x);
    rd_exp(0, 16'h4003, IRQ_ON ? 8'h87 : 8'h83, "expiry_beats_clear");
    check("irq_held", irq[0], IRQ_ON);

    for (int i = 0; i < 4; i++) begin
      gap(7);
      xact(0, 1'b0, 16'h4004, 8'h00, 1'b0, rd, acc);
      v = 3 - ((acc - 1 - e) % 4);
      check("autoreload_count", rd, v);
      last_rd[0] = 8'(v);
    end

    // Clear flag and disable on a non-expiry edge.
    x = e + 2;
    while (x - 2 < cyc) x += 4;
    while (cyc < x - 2) @(negedge clk);
    wr(0, 16'h4003, 8'h80);
    rd_exp(0, 16'h4003, 8'h00, "clear_and_disable");
    check("irq_after_clear", irq[0], 0);

    // Longer reload: count low reads and high-byte snapshot.
    wr(0, 16'h4001, 8'h05);
    wr(0, 16'h4002, 8'h01);
    wr(0, 16'h4003, 8'h03);
    e = last_acc;
    for (int i = 0; i < 5; i++) begin
      gap(15);
      xact(0, 1'b0, 16'h4004, 8'h00, 1'b0, rd, acc);
      v = 16'h0105 - (acc - 1 - e);
      check("count_low", rd, v & 8'hFF);
      last_rd[0] = 8'(v);
      rd_exp(0, 16'h4005, 8'((v >> 8) & 8'hFF), "snapshot_high");
    end

    // Disable written on the expiry edge: disable wins, flag still sets.
    wr(0, 16'h4003, 8'h00);
    wr(0, 16'h4001, 8'h03);
    wr(0, 16'h4002, 8'h00);
    wr(0, 16'h4003, 8'h03);
    e = last_acc;
    x = e + 4;
    while (cyc < x - 2) @(negedge clk);
    wr(0, 16'h4003, 8'h00);
    check("disable_on_expiry_edge", last_acc, x);
    rd_exp(0, 16'h4003, 8'h80, "disable_beats_expiry");
    wr(0, 16'h4003, 8'h80);
    rd_exp(0, 16'h4003, 8'h00, "flag_cleared");

    // Reset during the wait phase of a write aborts it.
    wr(1, 16'h0010, 8'h11);
    req[1] = 1'b1; rw[1] = 1'b1; ah[1] = 8'h00; al[1] = 8'h10; wd[1] = 8'hFF;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", rdy[1], 1);
    check("rst_ack", ack[1], 0);
    check("rst_rdata", rdata[1], 8'h00);
    check("rst_oe", oe[1], 0);
    check("rst_disp", disp[1], 8'h00);
    check("rst_irq", irq[1], 0);
    check("rst_disp_dut0", disp[0], 8'h00);
    rst = 1'b0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    disp_m[0]  = 8'h00; disp_m[1]  = 8'h00;
    @(negedge clk);
    rd_exp(1, 16'h0010, 8'h11, "ram_survives_reset");
    rd_exp(0, 16'h0923, model_read(0, 16'h0923), "dut0_ram_after_reset");
    rd_exp(0, 16'h4003, 8'h00, "ctrl_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's memory transaction interface: the target that accepts CPU read/write requests, decodes the 16-bit address, and returns data. Contains a mirrored on-chip RAM, a display latch for the seven-segment driver, and a 16-bit programmable down-counter timer, with configurable wait states signalled through a ready/acknowledge handshake. Sits in the top level opposite the CPU, replacing the current test memory.

## Interface
- WAIT_STATES, 0: extra cycles inserted between request capture and access (0–15).
- RAM_AW, 11: RAM address width; 2^RAM_AW bytes, mirrored across $0000–$1FFF.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  one-cycle request strobe; address, rw and write data valid with it.
- mem_addr_h  in  8  address high byte.
- mem_addr_l  in  8  address low byte.
- mem_rw  in  1  0 = read, 1 = write.
- mem_wdata  in  8  write data.
- mem_rdy  out  1  high when a new request will be accepted.
- mem_ack  out  1  one-cycle completion pulse, reads and writes.
- mem_rdata  out  8  read data; valid with mem_ack, held until the next read ack.
- mem_rdata_oe  out  1  high with mem_ack on reads; top level drives the data bus from it.
- disp_out  out  8  display latch contents, to the seven-segment path.
- irq  out  1  timer interrupt (see Configuration).

## Operation
- Address map:
  - $0000–$1FFF: RAM, index = addr[RAM_AW-1:0].
  - $4000: display latch, R/W.
  - $4001/$4002: reload low/high, R/W.
  - $4003: control, R/W. bit0 enable, bit1 auto-reload, bit2 irq enable, bit7 expired. bit7 reads the flag; writing 1 to bit7 clears it.
  - $4004: count low, read-only. Reading it snapshots count high.
  - $4005: snapshot high, read-only.
  - Everything else is unmapped: reads return the previous mem_rdata (open bus), writes are dropped, and both are still acked.
- FSM states IDLE, WAIT, ACCESS.
  - IDLE: on mem_req, capture addr/rw/wdata. Go to WAIT with counter = WAIT_STATES−1 if WAIT_STATES > 0, otherwise go to ACCESS.
  - WAIT: decrement the counter; go to ACCESS when it is 0.
  - ACCESS: perform the write, or register the read result into mem_rdata. Set mem_ack (and mem_rdata_oe for reads) for the next cycle. Return to IDLE.
- mem_rdy = (state == IDLE). A mem_req while mem_rdy is low is ignored.
- Timer:
  - When enabled, count decrements by 1 every clk.
  - On an enabled cycle with count == 0, set expired. If auto-reload, count ← reload; otherwise clear enable.
  - A write that sets enable from 0 to 1 loads count ← {reload_h, reload_l}.
  - Reload writes while running take effect at the next reload.
- Simultaneous events:
  - If expiry coincides with a CPU write clearing bit7, expiry wins and the flag stays 1.
  - If expiry coincides with a control write clearing enable, the disable wins and the flag still sets.

## Timing
- Read/write latency: request sampled at edge 0; mem_ack high during the cycle following edge 1+WAIT_STATES.
- mem_rdy returns high in the ack cycle, so a back-to-back request may be issued then. Maximum throughput is one transaction per 2+WAIT_STATES cycles.
- RAM is synchronous: one read port and one write port, used only in ACCESS.
- Reset values: state IDLE, mem_rdy 1, mem_ack 0, mem_rdata 8'h00, mem_rdata_oe 0, disp_out 8'h00, all timer registers 0, irq 0. RAM contents are not reset.
- Reset mid-transaction aborts it: no ack, and no RAM or register write unless ACCESS had already completed.

## Configuration
- MEM_RESP_TIMER_IRQ_EN defined: irq = expired & control bit2, registered, so it rises one cycle after expired sets. It stays high until the flag is cleared or bit2 is written 0.
- Not defined: irq is tied 0, and control bit2 reads 0 and ignores writes.

## Structure
- Shared package mem_resp_pkg: region base/limit constants, register offsets ($4000–$4005), control bit positions, FSM state enum.
- One sub-module, resp_timer, containing the counter, reload, control/expired logic, snapshot register and irq generation. The top handles decode, FSM, RAM and the display latch.

## Test plan
- Write $0123 ← 8'hA5, then read $0923 (mirror), WAIT_STATES=0 → mem_ack 2 cycles after each request, read returns 8'hA5, mem_rdy low for exactly 1 cycle per request.
- WAIT_STATES=3: read $0000 after writing 8'h3C → ack 5 cycles after request; a mem_req pulsed mid-wait is ignored with no extra ack.
- Write $4000 ← 8'h7E → disp_out = 8'h7E in the cycle after ack; read $4000 returns 8'h7E; read $2000 returns the previous mem_rdata unchanged with mem_ack 1.
- Reload = 16'h0003, control ← 8'h03 → expired set 4 cycles after enable takes effect, count reloads to 3; with irq enable and macro defined, irq high the next cycle. Write control bit7=1 on the same cycle as the next expiry → flag remains 1.
- Assert rst during WAIT of a write to $0010 ← 8'hFF → no ack, mem_rdy 1 and all outputs at reset values; subsequent read of $0010 returns the pre-reset contents.
